// File: rtl/mdio_peripheral.sv
// MDIO management slave: decodes 32-bit controller frames and performs one register-file access per frame.
// Optional PHY address filter is compiled in with `define MDIO_PHY_FILTER_EN.
module mdio_peripheral #(
    parameter logic [4:0] PHY_ADDR = 5'b00001
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        MEM_WR,
    output logic        MEM_RD,
    input  logic [15:0] RD_DATA,
    output logic        FRAME_ERR
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_TA     = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;

`ifdef MDIO_PHY_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic [2:0]  state;
    logic [4:0]  cnt;
    logic [12:0] hdr;
    logic [13:0] hdr_next;
    logic [14:0] wsh;
    logic [15:0] tx;
    logic        hdr_bad;
    logic        phy_ok;
    logic        is_read;

    // hdr_next is the complete ST/OP/PHYAD/REGAD header at edge 13
    assign hdr_next = {hdr, MDIO_OUT};
    assign hdr_bad  = (hdr_next[13:12] != 2'b01) || (hdr_next[11:10] == 2'b00) ||
                      (hdr_next[11:10] == 2'b11);
    assign phy_ok   = !FILTER_EN || (hdr_next[9:5] == PHY_ADDR);
    assign is_read  = (hdr[11:10] == 2'b10);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hdr        <= '0;
            wsh        <= '0;
            tx         <= '0;
            MDIO_IN    <= 1'b0;
            MDIO_IN_OE <= 1'b0;
            ADDR       <= '0;
            WR_DATA    <= '0;
            MEM_WR     <= 1'b0;
            MEM_RD     <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            MEM_WR    <= 1'b0;
            MEM_RD    <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (MDIO_OE) begin
                        hdr   <= {12'b0, MDIO_OUT};
                        cnt   <= 5'd1;
                        state <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    hdr <= hdr_next[12:0];
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd13) begin
                        if (hdr_bad) begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_DRAIN;
                        end else if (!phy_ok) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_TA;
                            if (hdr_next[11:10] == 2'b10) begin
                                MEM_RD <= 1'b1;
                                ADDR   <= hdr_next[4:0];
                            end
                        end
                    end
                end
                S_TA: begin
                    cnt <= cnt + 5'd1;
                    // edge 14 latches memory data, edge 15 presents its MSB
                    if (is_read) begin
                        if (cnt == 5'd14) begin
                            tx <= RD_DATA;
                        end else begin
                            MDIO_IN    <= tx[15];
                            MDIO_IN_OE <= 1'b1;
                            tx         <= {tx[14:0], 1'b0};
                        end
                    end
                    if (cnt == 5'd15)
                        state <= is_read ? S_RDATA : S_WDATA;
                end
                S_WDATA: begin
                    if (cnt == 5'd31) begin
                        WR_DATA <= {wsh, MDIO_OUT};
                        ADDR    <= hdr[4:0];
                        MEM_WR  <= 1'b1;
                        cnt     <= '0;
                        state   <= S_IDLE;
                    end else begin
                        wsh <= {wsh[13:0], MDIO_OUT};
                        cnt <= cnt + 5'd1;
                    end
                end
                S_RDATA: begin
                    if (cnt == 5'd31) begin
                        MDIO_IN    <= 1'b0;
                        MDIO_IN_OE <= 1'b0;
                        cnt        <= '0;
                        state      <= S_IDLE;
                    end else begin
                        MDIO_IN <= tx[15];
                        tx      <= {tx[14:0], 1'b0};
                        cnt     <= cnt + 5'd1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == 5'd31) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_peripheral.sv
// Directed bench for mdio_peripheral: per-edge checks of strobes, held outputs and read serialization.
module tb_mdio_peripheral;

`ifdef MDIO_PHY_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        CLK;
    logic        RESET;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic        MDIO_IN;
    logic        MDIO_IN_OE;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        MEM_WR;
    logic        MEM_RD;
    logic [15:0] RD_DATA;
    logic        FRAME_ERR;

    int checks = 0;
    int failures = 0;
    logic [4:0]  addr_hold = '0;
    logic [15:0] wdata_hold = '0;

    mdio_peripheral #(.PHY_ADDR(5'd1)) dut (
        .CLK(CLK), .RESET(RESET), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
        .MDIO_IN(MDIO_IN), .MDIO_IN_OE(MDIO_IN_OE), .ADDR(ADDR), .WR_DATA(WR_DATA),
        .MEM_WR(MEM_WR), .MEM_RD(MEM_RD), .RD_DATA(RD_DATA), .FRAME_ERR(FRAME_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mdio_in"}, {15'b0, MDIO_IN}, 16'h0);
        chk({tag, "_mdio_in_oe"}, {15'b0, MDIO_IN_OE}, 16'h0);
        chk({tag, "_addr"}, {11'b0, ADDR}, 16'h0);
        chk({tag, "_wr_data"}, WR_DATA, 16'h0);
        chk({tag, "_mem_wr"}, {15'b0, MEM_WR}, 16'h0);
        chk({tag, "_mem_rd"}, {15'b0, MEM_RD}, 16'h0);
        chk({tag, "_frame_err"}, {15'b0, FRAME_ERR}, 16'h0);
    endtask

    function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                       input logic [4:0] phy, input logic [4:0] rg,
                                       input logic [15:0] data);
        return {st, op, phy, rg, 2'b10, data};
    endfunction

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge CLK);
            MDIO_OE  = 1'b0;
            MDIO_OUT = 1'b0;
            @(posedge CLK);
            #1;
            chk("idle_mem_wr", {15'b0, MEM_WR}, 16'h0);
            chk("idle_mem_rd", {15'b0, MEM_RD}, 16'h0);
            chk("idle_frame_err", {15'b0, FRAME_ERR}, 16'h0);
            chk("idle_mdio_in_oe", {15'b0, MDIO_IN_OE}, 16'h0);
            chk("idle_addr", {11'b0, ADDR}, {11'b0, addr_hold});
            chk("idle_wr_data", WR_DATA, wdata_hold);
        end
    endtask

    task automatic run_frame(input logic [31:0] f, input logic [15:0] rd,
                             input bit exp_wr, input bit exp_rd, input bit exp_err,
                             input int oe_off_at, input int abort_at);
        logic exp_in;
        logic exp_oe;
        RD_DATA = rd;
        for (int k = 0; k < 32; k++) begin
            @(negedge CLK);
            MDIO_OUT = f[31-k];
            MDIO_OE  = (k < oe_off_at);
            @(posedge CLK);
            #1;
            if (k == 13 && exp_rd) addr_hold = f[22:18];
            if (k == 31 && exp_wr) begin
                addr_hold  = f[22:18];
                wdata_hold = f[15:0];
            end
            exp_in = 1'b0;
            exp_oe = 1'b0;
            if (exp_rd && k >= 15 && k <= 30) begin
                exp_oe = 1'b1;
                exp_in = rd[30-k];
            end
            chk("mem_rd", {15'b0, MEM_RD}, {15'b0, (k == 13) && exp_rd});
            chk("mem_wr", {15'b0, MEM_WR}, {15'b0, (k == 31) && exp_wr});
            chk("frame_err", {15'b0, FRAME_ERR}, {15'b0, (k == 13) && exp_err});
            chk("mdio_in_oe", {15'b0, MDIO_IN_OE}, {15'b0, exp_oe});
            chk("mdio_in", {15'b0, MDIO_IN}, {15'b0, exp_in});
            chk("addr", {11'b0, ADDR}, {11'b0, addr_hold});
            chk("wr_data", WR_DATA, wdata_hold);
            if (k == abort_at) begin
                RESET = 1'b0;
                #1;
                addr_hold  = '0;
                wdata_hold = '0;
                chk_zero("abort");
                @(negedge CLK);
                MDIO_OE = 1'b0;
                @(negedge CLK);
                RESET = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        RESET    = 1'b0;
        MDIO_OUT = 1'b0;
        MDIO_OE  = 1'b0;
        RD_DATA  = '0;
        #12;
        chk_zero("reset");
        @(negedge CLK);
        RESET = 1'b1;
        idle(2);

        run_frame(mk(2'b01, 2'b01, 5'd1, 5'd2, 16'h3C33), 16'h0, 1'b1, 1'b0, 1'b0, 32, 99);
        idle(1);
        run_frame(mk(2'b01, 2'b10, 5'd1, 5'd4, 16'h0000), 16'hA5A5, 1'b0, 1'b1, 1'b0, 14, 99);
        idle(1);
        // write then read back-to-back with MDIO_OE held
        run_frame(mk(2'b01, 2'b01, 5'd1, 5'd7, 16'h1234), 16'h0, 1'b1, 1'b0, 1'b0, 32, 99);
        run_frame(mk(2'b01, 2'b10, 5'd1, 5'd9, 16'h0000), 16'h5A3C, 1'b0, 1'b1, 1'b0, 32, 99);
        idle(1);
        run_frame(mk(2'b01, 2'b01, 5'd5, 5'd3, 16'hBEEF), 16'h0, !FILT, 1'b0, 1'b0, 32, 99);
        idle(1);
        run_frame(mk(2'b00, 2'b01, 5'd1, 5'd3, 16'h1111), 16'h0, 1'b0, 1'b0, 1'b1, 32, 99);
        run_frame(mk(2'b01, 2'b11, 5'd1, 5'd3, 16'h2222), 16'h0, 1'b0, 1'b0, 1'b1, 32, 99);
        run_frame(mk(2'b01, 2'b01, 5'd1, 5'd31, 16'hFFFF), 16'h0, 1'b1, 1'b0, 1'b0, 32, 99);
        idle(1);
        run_frame(mk(2'b01, 2'b01, 5'd1, 5'd10, 16'h0F0F), 16'h0, 1'b1, 1'b0, 1'b0, 20, 99);
        idle(1);
        run_frame(mk(2'b01, 2'b01, 5'd1, 5'd6, 16'h6666), 16'h0, 1'b0, 1'b0, 1'b0, 32, 20);
        idle(2);
        run_frame(mk(2'b01, 2'b01, 5'd1, 5'd8, 16'h8001), 16'h0, 1'b1, 1'b0, 1'b0, 32, 99);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
